// File: rtl/full_adder_behavioral.sv
// Parameterised ripple-carry full adder: combinational sum/carry out of x + y + cin,
// plus a one-cycle registered copy qualified by out_valid.
module full_adder_behavioral #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic [WIDTH-1:0] s_q,
    output logic             cout_q,
    output logic             out_valid
);

    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;

    logic [WIDTH-1:0] s_d;
    logic             cout_d;
    logic             out_valid_d;
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             out_valid_r;

    // Ripple chain of per-bit full-adder cells; every bit is assigned on every pass.
    always_comb begin
        carry_s    = '0;
        sum_s      = '0;
        carry_s[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum_s[i]     = x[i] ^ y[i] ^ carry_s[i];
            carry_s[i+1] = (x[i] & y[i]) | (x[i] & carry_s[i]) | (y[i] & carry_s[i]);
        end
    end

    assign s    = sum_s;
    assign cout = carry_s[WIDTH];

    // Next-state for the result register: capture on in_valid, otherwise hold and drop valid.
    always_comb begin
        s_d         = s_r;
        cout_d      = cout_r;
        out_valid_d = 1'b0;
        if (in_valid) begin
            s_d         = sum_s;
            cout_d      = carry_s[WIDTH];
            out_valid_d = 1'b1;
        end else begin
            s_d         = s_r;
            cout_d      = cout_r;
            out_valid_d = 1'b0;
        end
    end

    // Result register; asynchronous reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r         <= '0;
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            s_r         <= s_d;
            cout_r      <= cout_d;
            out_valid_r <= out_valid_d;
        end
    end

    assign s_q       = s_r;
    assign cout_q    = cout_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_full_adder_behavioral.sv
// Directed and swept checks of full_adder_behavioral at WIDTH = 1, 4, 8 and 16.
module tb_full_adder_behavioral;

    logic clk;
    logic rst_n;
    logic in_valid;

    logic        x1, y1, c1, s1, co1, sq1, coq1, ov1;
    logic [3:0]  x4, y4, s4, sq4;
    logic        c4, co4, coq4, ov4;
    logic [7:0]  x8, y8, s8, sq8;
    logic        c8, co8, coq8, ov8;
    logic [15:0] x16, y16, s16, sq16;
    logic        c16, co16, coq16, ov16;

    int errors = 0;
    int checks = 0;

    full_adder_behavioral #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .cin(c1), .in_valid(in_valid),
        .s(s1), .cout(co1), .s_q(sq1), .cout_q(coq1), .out_valid(ov1)
    );
    full_adder_behavioral #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .x(x4), .y(y4), .cin(c4), .in_valid(in_valid),
        .s(s4), .cout(co4), .s_q(sq4), .cout_q(coq4), .out_valid(ov4)
    );
    full_adder_behavioral #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .x(x8), .y(y8), .cin(c8), .in_valid(in_valid),
        .s(s8), .cout(co8), .s_q(sq8), .cout_q(coq8), .out_valid(ov8)
    );
    full_adder_behavioral #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .x(x16), .y(y16), .cin(c16), .in_valid(in_valid),
        .s(s16), .cout(co16), .s_q(sq16), .cout_q(coq16), .out_valid(ov16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b1;
        x1 = 1'b1; y1 = 1'b1; c1 = 1'b1;
        x4 = 4'hF; y4 = 4'hF; c4 = 1'b1;
        x8 = 8'hFF; y8 = 8'hFF; c8 = 1'b1;
        x16 = 16'hFFFF; y16 = 16'hFFFF; c16 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sq1, coq1, ov1} !== 3'b000) begin
            errors++; $display("FAIL reset_w1 got s_q/cout_q/valid=%b want 000", {sq1, coq1, ov1});
        end
        checks++;
        if ({sq8, coq8, ov8} !== 10'h000) begin
            errors++; $display("FAIL reset_w8 got %h want 000", {sq8, coq8, ov8});
        end
        checks++;
        if ({sq16, coq16, ov16} !== 18'h00000) begin
            errors++; $display("FAIL reset_w16 got %h want 00000", {sq16, coq16, ov16});
        end
        in_valid = 1'b0;
    endtask

    task automatic test_comb_w1;
        logic [2:0] vec [8];
        logic [1:0] exp_sc [8];
        vec    = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
        exp_sc = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
        for (int i = 0; i < 8; i++) begin
            {x1, y1, c1} = vec[i];
            #10;
            checks++;
            if ({s1, co1} !== exp_sc[i]) begin
                errors++;
                $display("FAIL comb_w1 xyc=%b got s,cout=%b want %b", vec[i], {s1, co1}, exp_sc[i]);
            end
        end
    endtask

    task automatic test_reg_w1;
        @(negedge clk);
        rst_n = 1'b1;
        {x1, y1, c1} = 3'b111;
        in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({sq1, coq1, ov1} !== 3'b111) begin
            errors++; $display("FAIL reg_w1 got s_q,cout_q,valid=%b want 111", {sq1, coq1, ov1});
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_ripple_w8;
        x8 = 8'hFF; y8 = 8'h00; c8 = 1'b1;
        #1;
        checks++;
        if ({co8, s8} !== 9'h100) begin
            errors++; $display("FAIL ripple_w8 got %h want 100", {co8, s8});
        end
        x8 = 8'hFF; y8 = 8'hFF; c8 = 1'b1;
        #1;
        checks++;
        if ({co8, s8} !== 9'h1FF) begin
            errors++; $display("FAIL allones_w8 got %h want 1ff", {co8, s8});
        end
        x8 = 8'h00; y8 = 8'h00; c8 = 1'b0;
        #1;
        checks++;
        if ({co8, s8} !== 9'h000) begin
            errors++; $display("FAIL zeros_w8 got %h want 000", {co8, s8});
        end
    endtask

    task automatic test_valid_gating_w8;
        @(negedge clk);
        x8 = 8'h12; y8 = 8'h34; c8 = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ov8, coq8, sq8} !== 10'h246) begin
            errors++; $display("FAIL capture_w8 got valid,cout_q,s_q=%h want 246", {ov8, coq8, sq8});
        end
        @(negedge clk);
        x8 = 8'hAA; y8 = 8'h55; c8 = 1'b1; in_valid = 1'b0;
        #1;
        checks++;
        if ({co8, s8} !== 9'h100) begin
            errors++; $display("FAIL comb_new_w8 got %h want 100", {co8, s8});
        end
        @(posedge clk); #1;
        checks++;
        if ({ov8, coq8, sq8} !== 10'h046) begin
            errors++; $display("FAIL hold_w8 got valid,cout_q,s_q=%h want 046", {ov8, coq8, sq8});
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        x8 = 8'hF0; y8 = 8'h20; c8 = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ov8, coq8, sq8} !== 10'h311) begin
            errors++; $display("FAIL pre_reset_w8 got %h want 311", {ov8, coq8, sq8});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ov8, coq8, sq8} !== 10'h000) begin
            errors++; $display("FAIL async_clear_w8 got %h want 000", {ov8, coq8, sq8});
        end
        x8 = 8'h7F; y8 = 8'h01; c8 = 1'b0;
        #1;
        checks++;
        if ({co8, s8} !== 9'h080) begin
            errors++; $display("FAIL comb_in_reset_w8 got %h want 080", {co8, s8});
        end
        @(posedge clk); #1;
        checks++;
        if ({ov8, coq8, sq8} !== 10'h000) begin
            errors++; $display("FAIL reset_held_w8 got %h want 000", {ov8, coq8, sq8});
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
    endtask

    task automatic test_random_sweep;
        logic [1:0]  e1;
        logic [4:0]  e4;
        logic [16:0] e16;
        logic [1:0]  r1;
        logic [4:0]  r4;
        logic [16:0] r16;
        logic        rv;
        r1 = {coq1, sq1}; r4 = {coq4, sq4}; r16 = {coq16, sq16}; rv = ov16;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            x1 = 1'($urandom); y1 = 1'($urandom); c1 = 1'($urandom);
            x4 = 4'($urandom); y4 = 4'($urandom); c4 = 1'($urandom);
            x16 = 16'($urandom); y16 = 16'($urandom); c16 = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            e1  = {1'b0, x1} + {1'b0, y1} + {1'b0, c1};
            e4  = {1'b0, x4} + {1'b0, y4} + {4'h0, c4};
            e16 = {1'b0, x16} + {1'b0, y16} + {16'h0, c16};
            #1;
            checks++;
            if ({co1, s1} !== e1 || {co4, s4} !== e4 || {co16, s16} !== e16) begin
                errors++;
                $display("FAIL sweep_comb n=%0d got %h/%h/%h want %h/%h/%h",
                         n, {co1, s1}, {co4, s4}, {co16, s16}, e1, e4, e16);
            end
            if (in_valid) begin
                r1 = e1; r4 = e4; r16 = e16; rv = 1'b1;
            end else begin
                rv = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if ({coq1, sq1} !== r1 || {coq4, sq4} !== r4 || {coq16, sq16} !== r16 ||
                ov1 !== rv || ov4 !== rv || ov16 !== rv) begin
                errors++;
                $display("FAIL sweep_reg n=%0d got %h/%h/%h v=%b%b%b want %h/%h/%h v=%b",
                         n, {coq1, sq1}, {coq4, sq4}, {coq16, sq16}, ov1, ov4, ov16,
                         r1, r4, r16, rv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_comb_w1();
        test_reg_w1();
        test_ripple_w8();
        test_valid_gating_w8();
        test_async_reset();
        test_random_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
